// File: rtl/mm_pkg.sv
// Shared definitions for the Cannon matrix-multiply block: sequencer states,
// element width and a constant-evaluable log2 helper.
package mm_pkg;

  localparam int ELEM_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SKEW,
    MAC,
    WAIT,
    SHIFT,
    OUT
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cannon_sequencer_step_counter.sv
// Up-counter with synchronous clear, increment and hold; tc flags count == MAX.
// hold wins over clr so a stalled sequencer keeps its indices.
module step_counter #(
  parameter int W   = 2,
  parameter int MAX = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (!hold) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + W'(1);
      end
    end
  end

  assign tc = (count == W'(MAX));

endmodule

// File: rtl/cannon_sequencer.sv
// Sequencer for block-partitioned Cannon multiply: load, skew, MAC rounds with
// shifts between them, then a valid/ack handshake towards the consumer.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | copy A/B blocks into tiles, clear accumulators
// SKEW  | initial alignment, SQRT_P-1 steps
// MAC   | accumulate tile products
// WAIT  | MAC_LAT settle cycles after each MAC
// SHIFT | rotate A left / B up, advance round
// OUT   | result final, hold out_valid until out_ack
module cannon_sequencer
  import mm_pkg::*;
#(
  parameter int  N       = 4,
  parameter int  SQRT_P  = 2,
  parameter int  MAC_LAT = 1,
  localparam int CNT_W   = clog2((SQRT_P > MAC_LAT + 1) ? SQRT_P : MAC_LAT + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             out_ack,
  output logic             load_en,
  output logic             clear_acc,
  output logic             skew_en,
  output logic [CNT_W-1:0] skew_step,
  output logic             mac_en,
  output logic             shift_en,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             out_valid,
  output logic             done
);

  if (SQRT_P < 1) begin : g_bad_grid
    $error("cannon_sequencer: SQRT_P must be >= 1");
  end
  if (SQRT_P >= 1 && (N % SQRT_P) != 0) begin : g_bad_n
    $error("cannon_sequencer: N must be divisible by SQRT_P");
  end

  localparam int SKEW_MAX = (SQRT_P > 1) ? SQRT_P - 2 : 0;
  localparam int WAIT_MAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

  state_t state, state_n;

  logic skew_clr, skew_inc, skew_tc;
  logic rnd_clr, rnd_inc, rnd_tc;
  logic wait_clr, wait_inc, wait_tc;
  logic ack_take;
  logic [CNT_W-1:0] wait_cnt_unused;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= ack_take;
    end
  end

  always_comb begin
    state_n   = state;
    load_en   = 1'b0;
    clear_acc = 1'b0;
    skew_en   = 1'b0;
    mac_en    = 1'b0;
    shift_en  = 1'b0;
    skew_clr  = 1'b0;
    skew_inc  = 1'b0;
    rnd_clr   = 1'b0;
    rnd_inc   = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && start) state_n = LOAD;
      end
      LOAD: begin
        load_en   = enable;
        clear_acc = enable;
        if (enable) state_n = (SQRT_P > 1) ? SKEW : MAC;
      end
      SKEW: begin
        skew_en = enable;
        if (enable) begin
          if (skew_tc) begin
            skew_clr = 1'b1;
            state_n  = MAC;
          end else begin
            skew_inc = 1'b1;
          end
        end
      end
      MAC: begin
        mac_en = enable;
        if (enable) begin
          if (MAC_LAT > 0) state_n = WAIT;
          else             state_n = rnd_tc ? OUT : SHIFT;
        end
      end
      WAIT: begin
        if (enable) begin
          if (wait_tc) begin
            wait_clr = 1'b1;
            state_n  = rnd_tc ? OUT : SHIFT;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      SHIFT: begin
        shift_en = enable;
        if (enable) begin
          rnd_inc = 1'b1;
          state_n = MAC;
        end
      end
      OUT: begin
        // The handshake is honoured even while stalled.
        if (out_ack) begin
          ack_take = 1'b1;
          rnd_clr  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  step_counter #(.W(CNT_W), .MAX(SKEW_MAX)) u_skew_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (skew_clr),
    .inc   (skew_inc),
    .hold  (~enable),
    .count (skew_step),
    .tc    (skew_tc)
  );

  step_counter #(.W(CNT_W), .MAX(SQRT_P - 1)) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (rnd_clr),
    .inc   (rnd_inc),
    .hold  (~enable & ~ack_take),
    .count (round),
    .tc    (rnd_tc)
  );

  step_counter #(.W(CNT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .hold  (~enable),
    .count (wait_cnt_unused),
    .tc    (wait_tc)
  );

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

endmodule

// File: tb/tb_cannon_sequencer.sv
// Bench for cannon_sequencer: three parameter sets driven against a run-time
// model that derives every output from the cycle index within a run.
module tb_cannon_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] reset, start, enable, out_ack;
  logic [2:0] load_en, clear_acc, skew_en, mac_en, shift_en, busy, out_valid, done;
  logic [1:0] ss0, rd0;
  logic [2:0] ss1, rd1, ss2, rd2;
  logic [31:0] ow [3];

  cannon_sequencer #(.N(4), .SQRT_P(2), .MAC_LAT(1)) dut0 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .enable(enable[0]), .out_ack(out_ack[0]),
    .load_en(load_en[0]), .clear_acc(clear_acc[0]), .skew_en(skew_en[0]), .skew_step(ss0),
    .mac_en(mac_en[0]), .shift_en(shift_en[0]), .round(rd0), .busy(busy[0]),
    .out_valid(out_valid[0]), .done(done[0]));

  cannon_sequencer #(.N(8), .SQRT_P(4), .MAC_LAT(0)) dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .enable(enable[1]), .out_ack(out_ack[1]),
    .load_en(load_en[1]), .clear_acc(clear_acc[1]), .skew_en(skew_en[1]), .skew_step(ss1),
    .mac_en(mac_en[1]), .shift_en(shift_en[1]), .round(rd1), .busy(busy[1]),
    .out_valid(out_valid[1]), .done(done[1]));

  cannon_sequencer #(.N(4), .SQRT_P(1), .MAC_LAT(2)) dut2 (
    .clk(clk), .reset(reset[2]), .start(start[2]), .enable(enable[2]), .out_ack(out_ack[2]),
    .load_en(load_en[2]), .clear_acc(clear_acc[2]), .skew_en(skew_en[2]), .skew_step(ss2),
    .mac_en(mac_en[2]), .shift_en(shift_en[2]), .round(rd2), .busy(busy[2]),
    .out_valid(out_valid[2]), .done(done[2]));

  // [15:12] round, [11:8] skew_step, [7] done, [6] out_valid, [5] busy,
  // [4] shift, [3] mac, [2] skew, [1] clear_acc, [0] load
  assign ow[0] = {16'd0, 2'd0, rd0, 2'd0, ss0, done[0], out_valid[0], busy[0],
                  shift_en[0], mac_en[0], skew_en[0], clear_acc[0], load_en[0]};
  assign ow[1] = {16'd0, 1'b0, rd1, 1'b0, ss1, done[1], out_valid[1], busy[1],
                  shift_en[1], mac_en[1], skew_en[1], clear_acc[1], load_en[1]};
  assign ow[2] = {16'd0, 1'b0, rd2, 1'b0, ss2, done[2], out_valid[2], busy[2],
                  shift_en[2], mac_en[2], skew_en[2], clear_acc[2], load_en[2]};

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
  endtask

  function automatic int sp_of(input int k);
    case (k)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int ml_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  // start-to-valid latency: 1 + (SP-1) + SP*(1+ML) + (SP-1) + 1
  function automatic int lat_of(input int k);
    return sp_of(k) * (ml_of(k) + 3);
  endfunction

  // Model: t_m = run cycle index (0 = idle), advancing only on enabled cycles.
  int t_m [3] = '{0, 0, 0};
  bit done_m [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int lat;
      lat = lat_of(k);
      if (!reset[k]) begin
        t_m[k]    = 0;
        done_m[k] = 1'b0;
      end else begin
        done_m[k] = (t_m[k] >= lat) && out_ack[k];
        if (t_m[k] == 0) begin
          if (enable[k] && start[k]) t_m[k] = 1;
        end else if (t_m[k] >= lat) begin
          if (out_ack[k]) t_m[k] = 0;
        end else if (enable[k]) begin
          t_m[k]++;
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input int k);
    int sp, ml, lat, tt, st, rd, u, o;
    logic en;
    logic [31:0] w;
    sp = sp_of(k); ml = ml_of(k); lat = lat_of(k); tt = t_m[k];
    en = enable[k];
    w = '0; st = 0; rd = 0;
    if (tt > 0) w[5] = 1'b1;
    if (tt >= lat) begin
      w[6] = 1'b1;
      rd = sp - 1;
    end else if (tt == 1) begin
      w[0] = en;
      w[1] = en;
    end else if (tt >= 2 && tt <= sp) begin
      w[2] = en;
      st = tt - 2;
    end else if (tt > sp) begin
      u  = tt - sp - 1;
      rd = u / (ml + 2);
      o  = u % (ml + 2);
      if (o == 0)      w[3] = en;
      if (o == ml + 1) w[4] = en;
    end
    w[7] = done_m[k];
    w[11:8]  = st[3:0];
    w[15:12] = rd[3:0];
    return w;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) check("cycle", k, ow[k], exp_word(k));
    end
  end

  task automatic do_run(input int k, input int stall_at, input bit noise,
                        output int lat, output int n_sk, output int n_mac,
                        output int n_sh, output int first_mac);
    int cyc;
    lat = 100; n_sk = 0; n_mac = 0; n_sh = 0; first_mac = -1;
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      enable[k]  = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5);
      start[k]   = noise && (cyc == 3);
      out_ack[k] = noise && (cyc == 3);
      @(negedge clk);
      if (ow[k][2]) n_sk++;
      if (ow[k][3]) begin
        n_mac++;
        if (first_mac < 0) first_mac = cyc;
      end
      if (ow[k][4]) n_sh++;
      if (ow[k][6]) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1 cyc++;
    end
    enable[k] = 1'b1; start[k] = 1'b0; out_ack[k] = 1'b0;
  endtask

  task automatic do_ack(input int k, input int hold, input bit with_start);
    repeat (hold) @(posedge clk);
    #1 out_ack[k] = 1'b1; start[k] = with_start;
    @(negedge clk);
    check("valid_held", k, 32'(ow[k][6]), 32'd1);
    @(posedge clk); #1 out_ack[k] = 1'b0; start[k] = 1'b0;
    @(negedge clk);
    check("done_pulse", k, {30'd0, ow[k][7], ow[k][5]}, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_restart", k, {30'd0, ow[k][7], ow[k][5]}, 32'd0);
  endtask

  int lat_tab [3]  = '{8, 12, 5};
  int skew_tab [3] = '{1, 3, 0};
  int mac_tab [3]  = '{2, 4, 1};
  int sh_tab [3]   = '{1, 3, 0};
  int fm_tab [3]   = '{3, 5, 2};

  initial begin
    int lat, nsk, nm, nsh, fm;
    reset = 3'b000; enable = 3'b111; start = 3'b000; out_ack = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 3'b111;
    @(negedge clk);
    checking = 1'b1;
    for (int k = 0; k < 3; k++) check("reset_idle", k, ow[k], 32'd0);

    for (int k = 0; k < 3; k++) begin
      do_run(k, 0, 1'b0, lat, nsk, nm, nsh, fm);
      check("latency", k, lat, lat_tab[k]);
      check("skew_count", k, nsk, skew_tab[k]);
      check("mac_count", k, nm, mac_tab[k]);
      check("shift_count", k, nsh, sh_tab[k]);
      check("first_mac", k, fm, fm_tab[k]);
      do_ack(k, 2, 1'b0);
    end

    do_run(0, 4, 1'b0, lat, nsk, nm, nsh, fm);
    check("stall_latency", 0, lat, 13);
    check("stall_mac_count", 0, nm, 2);
    check("stall_shift_count", 0, nsh, 1);
    do_ack(0, 2, 1'b0);

    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset[0] = 1'b0;
    @(negedge clk);
    check("shift_before_reset", 0, 32'(ow[0][4]), 32'd1);
    @(posedge clk); #1 reset[0] = 1'b1;
    @(negedge clk);
    check("after_reset", 0, ow[0], 32'd0);
    do_run(0, 0, 1'b0, lat, nsk, nm, nsh, fm);
    check("rerun_latency", 0, lat, 8);
    do_ack(0, 2, 1'b0);

    do_run(0, 0, 1'b1, lat, nsk, nm, nsh, fm);
    check("noise_latency", 0, lat, 8);
    check("noise_mac_count", 0, nm, 2);
    do_ack(0, 20, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        reset[k]   = ($urandom_range(0, 199) != 0);
        enable[k]  = ($urandom_range(0, 5) != 0);
        start[k]   = ($urandom_range(0, 7) == 0);
        out_ack[k] = ($urandom_range(0, 3) == 0);
      end
    end
    @(posedge clk); #1 reset = 3'b111; enable = 3'b111; start = 3'b000; out_ack = 3'b111;
    repeat (40) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("drained", k, 32'(ow[k][5]), 32'd0);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
